// File: rtl/collect_2x1_rr_seq_pkg.sv
// Shared constants for the 2-to-1 collection stage and its input FIFOs.
package collect_2x1_rr_seq_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // Every bit of a data word takes this value on reset.
  localparam logic DATA_RST_BIT = 1'b0;

  // Port-index encoding shared with the distribute switches.
  typedef enum logic {
    PORT_IN0 = 1'b0,
    PORT_IN1 = 1'b1
  } port_idx_e;

endpackage

// File: rtl/collect_2x1_rr_seq_fifo.sv
// Small synchronous FIFO, one per input branch of the collection stage.
// The caller must not push a full FIFO unless it pops it in the same cycle,
// and must not pop an empty FIFO.
module sync_fifo_seq
  import collect_2x1_rr_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Next-state pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness is tracked by the count, so stale words are never read.
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // When full and pushing with a pop, wr_ptr == rd_ptr: the read sees the old head before the write lands.
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/collect_2x1_rr_seq.sv
// Buffered 2-to-1 collection stage: two input FIFOs drained by a round-robin
// arbiter into a registered output with valid/ready backpressure. Inputs
// cannot be stalled, so a word arriving at a full FIFO is dropped and flagged.
module collect_2x1_rr_seq
  import collect_2x1_rr_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  output logic [1:0]              o_ready,
  output logic [1:0]              o_overflow,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data_bus,
  output logic                    o_src,
  input  logic                    i_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            push, pop, drop, full, empty;
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic [CW-1:0]         count   [2];

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  port_idx_e             src_q, src_d;
  port_idx_e             rr_last_q, rr_last_d;
  logic [1:0]            overflow_q, overflow_d;
  port_idx_e             grant;
  logic                  slot_free;

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    sync_fifo_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push[k]),
      .pop_i     (pop[k]),
      .wr_data_i (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_data_o (rd_data[k]),
      .full_o    (full[k]),
      .empty_o   (empty[k]),
      .count_o   (count[k])
    );

    // Status only: the FIFO occupancy is itself a register, so this reflects the last edge.
    assign o_ready[k] = (count[k] < CW'(FIFO_DEPTH));
  end

  // Arbitration, pop/push/drop decisions and output-register next state.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    src_d      = src_q;
    rr_last_d  = rr_last_q;
    grant      = PORT_IN0;
    pop        = 2'b00;
    slot_free  = !valid_q || i_ready;

    if (i_en && slot_free) begin
      if (!empty[0] && !empty[1]) begin
        grant = (rr_last_q == PORT_IN0) ? PORT_IN1 : PORT_IN0;
      end else if (!empty[1]) begin
        grant = PORT_IN1;
      end else begin
        grant = PORT_IN0;
      end

      if (empty != 2'b11) begin
        pop       = (grant == PORT_IN1) ? 2'b10 : 2'b01;
        valid_d   = 1'b1;
        data_d    = (grant == PORT_IN1) ? rd_data[1] : rd_data[0];
        src_d     = grant;
        rr_last_d = grant;
      end else begin
        // Nothing to send: release the slot, keep the last word and source visible.
        valid_d = 1'b0;
      end
    end

    // A full FIFO still accepts a word when its head leaves in the same cycle.
    push       = {2{i_en}} & i_valid & (~full | pop);
    drop       = {2{i_en}} & i_valid & ~push;
    overflow_d = overflow_q | drop;
  end

  // Output word, arbiter history and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= {DATA_WIDTH{DATA_RST_BIT}};
      src_q      <= PORT_IN0;
      rr_last_q  <= PORT_IN1;
      overflow_q <= 2'b00;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      src_q      <= src_d;
      rr_last_q  <= rr_last_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
  assign o_src      = src_q;
  assign o_overflow = overflow_q;

endmodule
